timer_bank: RTL

Multi-channel memory-mapped timer peripheral: the parametrised successor of the single TH/TL/TCON timer on the CPU peripheral bus. It provides NUM_CH independent up-counters of configurable width, each with auto-reload or one-shot mode, an optional per-channel prescaler and its own interrupt flag. All flags are combined into one level interrupt toward the CPU. It sits beside the existing peripherals on the shared rd/wr/addr/wdata/rdata bus and decodes only its own address window.

---
 rtl/timer_bank_pkg.sv | 27 ++
 rtl/timer_bank_if.sv | 18 +
 rtl/timer_channel.sv | 118 +++++++++++
 rtl/timer_bank.sv | 83 ++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// timer_bank shared definitions: register map offsets and TCON bit layout.
package timer_bank_pkg;

    typedef enum logic [3:0] {
        REG_TH    = 4'h0,
        REG_TL    = 4'h4,
        REG_TCON  = 4'h8,
        REG_PRESC = 4'hC
    } reg_e;

    localparam logic [7:0] OFF_IRQ_STAT = 8'hFC;
    localparam logic [7:0] CH_STRIDE    = 8'd16;

    localparam int TCON_EN   = 0;
    localparam int TCON_IE   = 1;
    localparam int TCON_FLAG = 2;
    localparam int TCON_OS   = 3;

    function automatic logic [3:0] ch_of(logic [7:0] off);
        return 4'(off / CH_STRIDE);
    endfunction

    function automatic logic [3:0] reg_of(logic [7:0] off);
        return 4'(off % CH_STRIDE);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Peripheral bus seen by timer_bank: read/write strobes, address, data.
interface timer_bank_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd, wr, addr, wdata,
        input  rdata
    );

    modport slave (
        input  rd, wr, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: counter, reload, optional divider, interrupt flag.
// Divider present only when TIMER_PRESCALER_EN is defined.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_th_i,
    input  logic             we_tl_i,
    input  logic             we_tcon_i,
    input  logic             we_presc_i,
    input  logic             clr_flag_i,
    input  logic [31:0]      wdata_i,
    output logic [WIDTH-1:0] th_o,
    output logic [WIDTH-1:0] tl_o,
    output logic [3:0]       tcon_o,
    output logic [15:0]      presc_o,
    output logic             flag_o
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] th_q, th_d;
    logic [WIDTH-1:0] tl_q, tl_d;
    logic en_q, en_d;
    logic ie_q, ie_d;
    logic os_q, os_d;
    logic flag_q, flag_d;
    logic tick;
    logic ovf;
    logic unused_w;

    assign unused_w = ^{wdata_i, we_presc_i};

`ifdef TIMER_PRESCALER_EN
    logic [15:0] presc_q;
    logic [15:0] div_q, div_d;

    assign tick    = (div_q == presc_q);
    assign presc_o = presc_q;

    // Writing PRESC restarts the divider so the new ratio starts clean.
    always_comb begin
        div_d = div_q;
        if (we_presc_i)
            div_d = '0;
        else if (en_q)
            div_d = tick ? '0 : div_q + 16'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            div_q   <= '0;
        end else begin
            if (we_presc_i)
                presc_q <= wdata_i[15:0];
            div_q <= div_d;
        end
    end
`else
    assign tick    = 1'b1;
    assign presc_o = '0;
`endif

    assign ovf = en_q && tick && (tl_q == MAX);

    always_comb begin
        th_d   = we_th_i ? wdata_i[WIDTH-1:0] : th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        os_d   = os_q;
        flag_d = flag_q;
        if (we_tl_i)
            tl_d = wdata_i[WIDTH-1:0];
        else if (en_q && tick)
            tl_d = ovf ? th_q : tl_q + WIDTH'(1);
        if (we_tcon_i) begin
            en_d = wdata_i[TCON_EN];
            ie_d = wdata_i[TCON_IE];
            os_d = wdata_i[TCON_OS];
        end else if (ovf && os_q) begin
            en_d = 1'b0;
        end
        // Clear first so a same-cycle overflow set takes priority.
        if (clr_flag_i || (we_tcon_i && wdata_i[TCON_FLAG]))
            flag_d = 1'b0;
        if (ovf && ie_q)
            flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            os_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            os_q   <= os_d;
            flag_q <= flag_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = {os_q, flag_q, ie_q, en_q};
    assign flag_o = flag_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel bus timer: address decode, read mux and interrupt OR.
// Optional per-channel prescaler enabled by TIMER_PRESCALER_EN.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0040
) (
    input  logic         clk,
    input  logic         reset,
    timer_bank_if.slave  bus,
    output logic         irqout
);

    logic [31:0] off;
    logic [7:0]  loff;
    logic [3:0]  ch_sel;
    logic [3:0]  reg_sel;
    logic        in_win;
    logic        stat_hit;
    logic        wr_win;

    // Window need not be 256-byte aligned, so decode on the offset.
    assign off      = bus.addr - BASE_ADDR;
    assign in_win   = (off[31:8] == '0);
    assign loff     = off[7:0];
    assign ch_sel   = ch_of(loff);
    assign reg_sel  = reg_of(loff);
    assign stat_hit = in_win && (loff == OFF_IRQ_STAT);
    assign wr_win   = bus.wr && in_win;

    logic [WIDTH-1:0] th_w    [NUM_CH];
    logic [WIDTH-1:0] tl_w    [NUM_CH];
    logic [3:0]       tcon_w  [NUM_CH];
    logic [15:0]      presc_w [NUM_CH];
    logic [NUM_CH-1:0] flag_w;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = wr_win && (ch_sel == 4'(c));

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .we_th_i   (hit && reg_sel == REG_TH),
            .we_tl_i   (hit && reg_sel == REG_TL),
            .we_tcon_i (hit && reg_sel == REG_TCON),
            .we_presc_i(hit && reg_sel == REG_PRESC),
            .clr_flag_i(bus.wr && stat_hit && bus.wdata[c]),
            .wdata_i   (bus.wdata),
            .th_o      (th_w[c]),
            .tl_o      (tl_w[c]),
            .tcon_o    (tcon_w[c]),
            .presc_o   (presc_w[c]),
            .flag_o    (flag_w[c])
        );
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && in_win) begin
            if (stat_hit)
                bus.rdata = 32'(flag_w);
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == 4'(c)) begin
                    case (reg_sel)
                        REG_TH:    bus.rdata = 32'(th_w[c]);
                        REG_TL:    bus.rdata = 32'(tl_w[c]);
                        REG_TCON:  bus.rdata = 32'(tcon_w[c]);
                        REG_PRESC: bus.rdata = 32'(presc_w[c]);
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign irqout = |flag_w;

endmodule
